// File: rtl/fcvt_pkg.sv
// fcvt_pkg: shared widths, constants and stage0 payload type for the int64 -> fp64 converter
package fcvt_pkg;
  localparam int FP64_W = 64;
  localparam int EXP_W = 11;
  localparam int MANT_W = 52;
  localparam logic [EXP_W-1:0] EXP_BIAS = 11'd1023;
  localparam logic [FP64_W-1:0] FP64_ZERO = 64'h0;
  localparam int TAG_MAX_W = 16;
  localparam int SRC_MAX_W = 8;
  typedef struct packed {
    logic [FP64_W-1:0] data;
    logic [TAG_MAX_W-1:0] tag;
    logic [SRC_MAX_W-1:0] src;
`ifdef FCVT_UNSIGNED_EN
    logic is_unsigned;
`endif
  } fcvt_op_t;
endpackage

// File: rtl/fcvt_i2d_core.sv
// fcvt_i2d_core: combinational int64 (or uint64) -> IEEE-754 double, truncating toward zero
module fcvt_i2d_core
  import fcvt_pkg::*;
(
  input  logic [FP64_W-1:0] in,
  input  logic              is_unsigned,
  output logic [FP64_W-1:0] out
);
  logic s;
  logic [FP64_W-1:0] mag, norm;
  logic [5:0] k;
  logic unused_bits;
  // magnitude, leading-one encode, normalise so the MSB lands at bit 63, then pack
  always_comb begin
    s = !is_unsigned && in[FP64_W-1];
    mag = s ? -in : in;
    k = '0;
    for (int i = 0; i < FP64_W; i++) k = mag[i] ? 6'(i) : k;
    norm = mag << (6'd63 - k);
    out = (mag == '0) ? FP64_ZERO : {s, EXP_BIAS + EXP_W'(k), norm[FP64_W-2 -: MANT_W]};
  end
  assign unused_bits = ^{norm[FP64_W-1], norm[EXP_W-1:0]};
endmodule

// File: rtl/fcvt_arb_sched.sv
// fcvt_arb_sched: round-robin shared int64->fp64 converter, 2-stage pipe, tagged response (opt. FCVT_UNSIGNED_EN)
module fcvt_arb_sched
  import fcvt_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int TAG_W = 4,
  localparam int SRC_W = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
`ifdef FCVT_UNSIGNED_EN
  input  logic [NUM_REQ-1:0]       req_unsigned,
`endif
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*64-1:0]    req_data,
  input  logic [NUM_REQ*TAG_W-1:0] req_tag,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [FP64_W-1:0]        resp_data,
  output logic [TAG_W-1:0]         resp_tag,
  output logic [SRC_W-1:0]         resp_src,
  output logic                     busy
);
  logic [SRC_W-1:0] ptr, win;
  logic any, v0, v1, adv0, adv1, is_uns, unused_hi;
  int j;
  fcvt_op_t op_d, op_q;
  logic [FP64_W-1:0] cvt;
  assign adv1 = !v1 || resp_ready;
  assign adv0 = !v0 || adv1;
  assign req_ready = (any && adv0) ? (NUM_REQ'(1) << win) : '0;
  assign resp_valid = v1;
  assign busy = v0 || v1;
  assign unused_hi = ^{op_q.tag, op_q.src};
  // round-robin search from ptr; lowest offset from ptr wins
  always_comb begin
    win = '0;
    any = 1'b0;
    j = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % NUM_REQ;
      if (req_valid[SRC_W'(j)]) begin
        win = SRC_W'(j);
        any = 1'b1;
      end
    end
  end
  // operand mux for the winning port
  always_comb begin
    op_d = '0;
    op_d.data = req_data[FP64_W*win +: FP64_W];
    op_d.tag = TAG_MAX_W'(req_tag[TAG_W*win +: TAG_W]);
    op_d.src = SRC_MAX_W'(win);
`ifdef FCVT_UNSIGNED_EN
    op_d.is_unsigned = req_unsigned[win];
`endif
  end
`ifdef FCVT_UNSIGNED_EN
  assign is_uns = op_q.is_unsigned;
`else
  assign is_uns = 1'b0;
`endif
  fcvt_i2d_core u_core (.in(op_q.data), .is_unsigned(is_uns), .out(cvt));
  // operand stage, result stage and arbitration pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v0 <= 1'b0;
      v1 <= 1'b0;
      ptr <= '0;
      op_q <= '0;
      resp_data <= '0;
      resp_tag <= '0;
      resp_src <= '0;
    end else begin
      if (adv0) v0 <= |req_ready;
      if (|req_ready) begin
        op_q <= op_d;
        ptr <= (win == SRC_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
      end
      if (adv1) v1 <= v0;
      if (adv1 && v0) begin
        resp_data <= cvt;
        resp_tag <= op_q.tag[TAG_W-1:0];
        resp_src <= op_q.src[SRC_W-1:0];
      end
    end
  end
endmodule

// File: tb/tb_fcvt_arb_sched.sv
// tb_fcvt_arb_sched: randomized bench with a queue-based reference model and literal pins
module tb_fcvt_arb_sched;
  localparam int N = 2;
  localparam int TW = 4;
  localparam int SW = 1;
  localparam int ITERS = 600;
  localparam int RST_AT = 400;
`ifdef FCVT_UNSIGNED_EN
  localparam int ND = 8;
`else
  localparam int ND = 6;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N-1:0] req_valid, req_ready;
  logic [N*64-1:0] req_data;
  logic [N*TW-1:0] req_tag;
  logic resp_valid, resp_ready, busy;
  logic [63:0] resp_data;
  logic [TW-1:0] resp_tag;
  logic [SW-1:0] resp_src;
`ifdef FCVT_UNSIGNED_EN
  logic [N-1:0] req_unsigned;
`endif
  always #5 clk = ~clk;

  fcvt_arb_sched #(.NUM_REQ(N), .TAG_W(TW)) dut (
    .clk(clk),
    .rst_n(rst_n),
`ifdef FCVT_UNSIGNED_EN
    .req_unsigned(req_unsigned),
`endif
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_data(req_data),
    .req_tag(req_tag),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_data(resp_data),
    .resp_tag(resp_tag),
    .resp_src(resp_src),
    .busy(busy)
  );

  typedef struct {
    logic [63:0] res;
    int tag;
    int src;
    int age;
    bit has_lit;
    logic [63:0] lit;
  } item_t;

  item_t q[$];
  bit pv[N], pu[N], took[N], plh[N];
  logic [63:0] pd[N], pll[N];
  logic [TW-1:0] pt[N];
  logic [63:0] dd[ND], dl[ND];
  bit du[ND];
  int ptr, di, n_tests, n_fail;

  function automatic logic [63:0] ref_cvt(logic [63:0] x, bit uns);
    logic [63:0] m, f;
    logic [51:0] man;
    bit s;
    int k;
    s = !uns && x[63];
    m = s ? -x : x;
    if (m == 64'd0) return 64'd0;
    k = 0;
    while (k < 63 && (m >> (k + 1)) != 64'd0) k++;
    f = m & ~(64'd1 << k);
    man = (k >= 52) ? 52'(f >> (k - 52)) : 52'(f << (52 - k));
    return {s, 11'(1023 + k), man};
  endfunction

  function automatic logic [63:0] rnd_data();
    logic [63:0] v;
    case ($urandom_range(0, 5))
      0: v = 64'd0;
      1: v = 64'($urandom_range(0, 200)) - 64'd100;
      2: v = {$urandom, $urandom};
      3: v = 64'h8000_0000_0000_0000;
      4: v = (64'd1 << $urandom_range(0, 63)) + 64'($urandom_range(0, 3));
      default: v = {$urandom, $urandom} >> $urandom_range(0, 63);
    endcase
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  initial begin
    int g;
    bit found, acc, ev, force_v;
    logic [N-1:0] exp_rr;
    item_t it_new;
    n_tests = 0;
    n_fail = 0;
    ptr = 0;
    di = 0;
    dd[0] = 64'd1;                  dl[0] = 64'h3FF0_0000_0000_0000; du[0] = 0;
    dd[1] = 64'd0;                  dl[1] = 64'h0;                   du[1] = 0;
    dd[2] = 64'hFFFF_FFFF_FFFF_FFFF; dl[2] = 64'hBFF0_0000_0000_0000; du[2] = 0;
    dd[3] = 64'd10;                 dl[3] = 64'h4024_0000_0000_0000; du[3] = 0;
    dd[4] = 64'h8000_0000_0000_0000; dl[4] = 64'hC3E0_0000_0000_0000; du[4] = 0;
    dd[5] = 64'h0020_0000_0000_0003; dl[5] = 64'h4340_0000_0000_0001; du[5] = 0;
`ifdef FCVT_UNSIGNED_EN
    dd[6] = 64'hFFFF_FFFF_FFFF_FFFF; dl[6] = 64'h43EF_FFFF_FFFF_FFFF; du[6] = 1;
    dd[7] = 64'hFFFF_FFFF_FFFF_FFFF; dl[7] = 64'hBFF0_0000_0000_0000; du[7] = 0;
    req_unsigned = '0;
`endif
    for (int i = 0; i < N; i++) begin
      pv[i] = 0; pu[i] = 0; took[i] = 0; plh[i] = 0; pd[i] = '0; pll[i] = '0; pt[i] = '0;
    end
    req_valid = '0;
    req_data = '0;
    req_tag = '0;
    resp_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_resp_data", resp_data, 64'd0);
    chk("rst_resp_tag", 64'(resp_tag), 64'd0);
    chk("rst_resp_src", 64'(resp_src), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    rst_n = 1'b1;
    for (int it = 0; it < ITERS; it++) begin
      @(negedge clk);
      force_v = (it >= 200 && it < 206) || (it >= 394 && it < 406);
      for (int i = 0; i < N; i++) begin
        if (!pv[i] || took[i]) begin
          plh[i] = 0;
          if (it < 12) begin
            pv[i] = 0;
            if (i == 0 && di < ND) begin
              pv[i] = 1; pd[i] = dd[di]; pu[i] = du[di]; plh[i] = 1; pll[i] = dl[di];
              pt[i] = (di == 0) ? TW'(3) : TW'(di);
              di++;
            end
          end else begin
            pv[i] = force_v || ($urandom_range(0, 3) != 0);
            pd[i] = rnd_data();
            pt[i] = TW'($urandom);
`ifdef FCVT_UNSIGNED_EN
            pu[i] = $urandom_range(0, 1) != 0;
`else
            pu[i] = 0;
`endif
          end
        end
        req_valid[i] = pv[i];
        req_data[64*i +: 64] = pd[i];
        req_tag[TW*i +: TW] = pt[i];
`ifdef FCVT_UNSIGNED_EN
        req_unsigned[i] = pu[i];
`endif
      end
      resp_ready = (it < 12) ? 1'b1 :
                   ((it >= 200 && it < 205) || (it >= 394 && it < 400)) ? 1'b0 :
                   ($urandom_range(0, 3) != 0);
      #1;
      found = 0;
      g = 0;
      for (int k = 0; k < N; k++)
        if (!found && pv[(ptr + k) % N]) begin
          g = (ptr + k) % N;
          found = 1;
        end
      acc = found && (q.size() < 2 || resp_ready);
      exp_rr = acc ? (N'(1) << g) : '0;
      ev = q.size() > 0 && q[0].age >= 1;
      chk("req_ready", 64'(req_ready), 64'(exp_rr));
      chk("resp_valid", 64'(resp_valid), 64'(ev));
      chk("busy", 64'(busy), 64'(q.size() > 0));
      if (it == RST_AT + 1) chk("post_rst_grant", 64'(req_ready), 64'd1);
      if (ev) begin
        chk("resp_data", resp_data, q[0].res);
        chk("resp_tag", 64'(resp_tag), 64'(q[0].tag));
        chk("resp_src", 64'(resp_src), 64'(q[0].src));
        if (q[0].has_lit) chk("resp_literal", resp_data, q[0].lit);
      end
      if (it == RST_AT) begin
        rst_n = 1'b0;
        #1;
        chk("midrst_resp_valid", 64'(resp_valid), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_resp_data", resp_data, 64'd0);
        q.delete();
        ptr = 0;
        for (int i = 0; i < N; i++) took[i] = 0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        continue;
      end
      if (ev && resp_ready) void'(q.pop_front());
      foreach (q[x]) q[x].age++;
      for (int i = 0; i < N; i++) took[i] = 0;
      if (acc) begin
        it_new.res = ref_cvt(pd[g], pu[g]);
        it_new.tag = int'(pt[g]);
        it_new.src = g;
        it_new.age = 0;
        it_new.has_lit = plh[g];
        it_new.lit = pll[g];
        q.push_back(it_new);
        ptr = (g + 1) % N;
        took[g] = 1;
      end
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
